// File: rtl/branch_predictor.sv
// branch_predictor: tournament local/gshare branch direction predictor; define PRED_STATS_EN for stat_total/stat_correct
module branch_predictor #(
  parameter int TABLE_BIT = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,
  input  logic                 query_valid,
  input  logic [31:0]          query_pc,
  output logic                 pred_valid,
  output logic                 pred_taken,
  output logic [TABLE_BIT-1:0] pred_g_ind,
  output logic [TABLE_BIT-1:0] pred_l_ind,
  input  logic                 upd_valid,
  input  logic                 upd_res,
  input  logic                 upd_correct,
  input  logic [TABLE_BIT-1:0] upd_g_ind,
  input  logic [TABLE_BIT-1:0] upd_l_ind
`ifdef PRED_STATS_EN
  ,
  output logic [31:0]          stat_total,
  output logic [31:0]          stat_correct
`endif
);
  localparam int N = 1 << TABLE_BIT;
  logic [1:0] lcnt [N];
  logic [1:0] gcnt [N];
  logic [1:0] chooser [N];
  logic [TABLE_BIT-1:0] ghr;
  logic [TABLE_BIT-1:0] q_l;
  logic [TABLE_BIT-1:0] q_g;
  logic lp;
  logic gp;
  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    return up ? (c == 2'd3 ? c : c + 2'd1) : (c == 2'd0 ? c : c - 2'd1);
  endfunction
  assign q_l = query_pc[TABLE_BIT:1];
  assign q_g = q_l ^ ghr;
  assign lp  = lcnt[upd_l_ind][1];
  assign gp  = gcnt[upd_g_ind][1];
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N; i++) begin
        lcnt[i]    <= 2'b01;
        gcnt[i]    <= 2'b01;
        chooser[i] <= 2'b01;
      end
      ghr        <= '0;
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_g_ind <= '0;
      pred_l_ind <= '0;
`ifdef PRED_STATS_EN
      stat_total   <= '0;
      stat_correct <= '0;
`endif
    end else if (rdy_in) begin
      pred_valid <= query_valid && !clear_in;
      if (query_valid) begin
        pred_taken <= chooser[q_l][1] ? gcnt[q_g][1] : lcnt[q_l][1];
        pred_g_ind <= q_g;
        pred_l_ind <= q_l;
      end
      if (upd_valid) begin
        lcnt[upd_l_ind] <= sat_step(lcnt[upd_l_ind], upd_res);
        gcnt[upd_g_ind] <= sat_step(gcnt[upd_g_ind], upd_res);
        if (lp != gp)
          chooser[upd_l_ind] <= sat_step(chooser[upd_l_ind], gp == upd_res);
        ghr <= {ghr[TABLE_BIT-2:0], upd_res};
`ifdef PRED_STATS_EN
        stat_total   <= stat_total + 32'd1;
        stat_correct <= stat_correct + {31'd0, upd_correct};
`endif
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: randomized and directed check of branch_predictor against an integer table model
module tb_branch_predictor;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        clear_in = 1'b0;
  logic        query_valid = 1'b0;
  logic [31:0] query_pc = '0;
  logic        upd_valid = 1'b0;
  logic        upd_res = 1'b0;
  logic        upd_correct = 1'b0;
  logic [7:0]  upd_g_ind = '0;
  logic [7:0]  upd_l_ind = '0;
  logic        pred_valid;
  logic        pred_taken;
  logic [7:0]  pred_g_ind;
  logic [7:0]  pred_l_ind;
`ifdef PRED_STATS_EN
  logic [31:0] stat_total;
  logic [31:0] stat_correct;
`endif
  int n_checks = 0;
  int n_fail = 0;
  bit go = 0;
  int lc [256];
  int gc [256];
  int ch [256];
  int ghr = 0;
  int m_pv = 0, m_pt = 0, m_pg = 0, m_pl = 0;
  int m_tot = 0, m_cor = 0;
  int ql, qg, lp, gp, r;

  always #5 clk_in = ~clk_in;

  branch_predictor #(.TABLE_BIT(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .query_valid(query_valid), .query_pc(query_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_g_ind(pred_g_ind), .pred_l_ind(pred_l_ind),
    .upd_valid(upd_valid), .upd_res(upd_res), .upd_correct(upd_correct),
    .upd_g_ind(upd_g_ind), .upd_l_ind(upd_l_ind)
`ifdef PRED_STATS_EN
    , .stat_total(stat_total), .stat_correct(stat_correct)
`endif
  );

  function automatic int clamp(input int c);
    return c < 0 ? 0 : (c > 3 ? 3 : c);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 256; i++) begin
        lc[i] = 1;
        gc[i] = 1;
        ch[i] = 1;
      end
      ghr = 0;
      m_pv = 0; m_pt = 0; m_pg = 0; m_pl = 0;
      m_tot = 0; m_cor = 0;
    end else if (rdy_in) begin
      ql = int'(query_pc >> 1) % 256;
      qg = ql ^ ghr;
      if (query_valid) begin
        m_pt = (ch[ql] >= 2) ? int'(gc[qg] >= 2) : int'(lc[ql] >= 2);
        m_pg = qg;
        m_pl = ql;
      end
      m_pv = int'(query_valid && !clear_in);
      if (upd_valid) begin
        r  = int'(upd_res);
        lp = int'(lc[upd_l_ind] >= 2);
        gp = int'(gc[upd_g_ind] >= 2);
        lc[upd_l_ind] = clamp(lc[upd_l_ind] + (r ? 1 : -1));
        gc[upd_g_ind] = clamp(gc[upd_g_ind] + (r ? 1 : -1));
        if (lp != gp)
          ch[upd_l_ind] = clamp(ch[upd_l_ind] + (gp == r ? 1 : -1));
        ghr = (ghr * 2 + r) % 256;
        m_tot++;
        m_cor += int'(upd_correct);
      end
    end
  end

  always @(negedge clk_in) begin
    if (go) begin
      chk("pred_valid", 32'(pred_valid), m_pv);
      if (m_pv != 0) begin
        chk("pred_taken", 32'(pred_taken), m_pt);
        chk("pred_g_ind", 32'(pred_g_ind), m_pg);
        chk("pred_l_ind", 32'(pred_l_ind), m_pl);
      end
`ifdef PRED_STATS_EN
      chk("stat_total", stat_total, m_tot);
      chk("stat_correct", stat_correct, m_cor);
`endif
    end
  end

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
    query_valid = 1'b0;
    upd_valid = 1'b0;
  endtask

  task automatic query(input logic [31:0] pc);
    query_valid = 1'b1;
    query_pc = pc;
  endtask

  task automatic upd(input logic res, input logic corr, input logic [7:0] li, input logic [7:0] gi);
    upd_valid = 1'b1;
    upd_res = res;
    upd_correct = corr;
    upd_l_ind = li;
    upd_g_ind = gi;
  endtask

  initial begin
    query(32'h100);
    step();
    step();
    chk("reset pred_valid", 32'(pred_valid), 0);
    chk("reset pred_taken", 32'(pred_taken), 0);
    chk("reset pred_g_ind", 32'(pred_g_ind), 0);
    chk("reset pred_l_ind", 32'(pred_l_ind), 0);
    rst_in = 1'b0;
    go = 1;
    query(32'h100);
    step();
    chk("first pred_valid", 32'(pred_valid), 1);
    chk("first l_ind", 32'(pred_l_ind), 32'h80);
    chk("first g_ind", 32'(pred_g_ind), 32'h80);
    chk("first taken", 32'(pred_taken), 0);
    upd(1, 1, 8'h80, 8'h80);
    step();
    upd(1, 1, 8'h80, 8'h80);
    step();
    query(32'h100);
    step();
    chk("trained g_ind", 32'(pred_g_ind), 32'h83);
    chk("trained taken", 32'(pred_taken), 1);
    upd(0, 0, 8'h10, 8'h11);
    step();
    upd(1, 0, 8'h20, 8'h10);
    step();
    upd(1, 0, 8'h20, 8'h10);
    step();
    upd(1, 0, 8'h10, 8'h10);
    step();
    for (int i = 0; i < 4; i++) begin
      upd(0, 1, 8'h30, 8'h11);
      step();
    end
    query(32'h20);
    step();
    chk("ghr four zeros g_ind", 32'(pred_g_ind), 32'h60);
    for (int i = 0; i < 4; i++) begin
      upd(0, 1, 8'h30, 8'h11);
      step();
    end
    query(32'h20);
    step();
    chk("chooser global g_ind", 32'(pred_g_ind), 32'h10);
    chk("chooser global taken", 32'(pred_taken), 1);
    rdy_in = 1'b0;
    query(32'h100);
    upd(1, 1, 8'h30, 8'h30);
    step();
    rdy_in = 1'b1;
    chk("frozen pred_valid", 32'(pred_valid), 1);
    chk("frozen g_ind", 32'(pred_g_ind), 32'h10);
    chk("frozen taken", 32'(pred_taken), 1);
    query(32'h60);
    step();
    chk("frozen ghr g_ind", 32'(pred_g_ind), 32'h30);
    chk("saturated low taken", 32'(pred_taken), 0);
    clear_in = 1'b1;
    query(32'h60);
    upd(1, 1, 8'h40, 8'h40);
    step();
    clear_in = 1'b0;
    chk("clear pred_valid", 32'(pred_valid), 0);
    query(32'h80);
    step();
    chk("clear still trains g_ind", 32'(pred_g_ind), 32'h41);
    for (int i = 0; i < 3000; i++) begin
      rst_in = ($urandom_range(0, 299) == 0);
      rdy_in = ($urandom_range(0, 9) != 0);
      clear_in = ($urandom_range(0, 9) == 0);
      query_valid = 1'($urandom_range(0, 1));
      query_pc = ($urandom & 32'hFFFF_FE01) | (32'($urandom_range(0, 15)) << 1);
      upd_valid = ($urandom_range(0, 2) != 0);
      upd_res = ($urandom_range(0, 3) != 0);
      upd_correct = 1'($urandom_range(0, 1));
      upd_l_ind = 8'($urandom_range(0, 15));
      upd_g_ind = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      @(posedge clk_in);
      @(negedge clk_in);
    end
    rst_in = 1'b0;
    rdy_in = 1'b1;
    clear_in = 1'b0;
    query_valid = 1'b0;
    upd_valid = 1'b0;
    query(32'h100);
    step();
    rst_in = 1'b1;
    query(32'h100);
    upd(1, 1, 8'h80, 8'h80);
    step();
    rst_in = 1'b0;
    chk("midrun reset pred_valid", 32'(pred_valid), 0);
    chk("midrun reset taken", 32'(pred_taken), 0);
    chk("midrun reset g_ind", 32'(pred_g_ind), 0);
    chk("midrun reset l_ind", 32'(pred_l_ind), 0);
    query($urandom);
    step();
    chk("post reset taken", 32'(pred_taken), 0);
    upd(1, 1, 8'h01, 8'h02);
    step();
    upd(0, 1, 8'h03, 8'h04);
    step();
    upd(1, 0, 8'h05, 8'h06);
    step();
`ifdef PRED_STATS_EN
    chk("stat_total literal", stat_total, 3);
    chk("stat_correct literal", stat_correct, 2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
